// File: rtl/mul_div_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: operation encoding (funct3 order)
// and the integration word type.
package mul_div_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [2:0] {
    mul_mul    = 3'b000,
    mul_mulh   = 3'b001,
    mul_mulhsu = 3'b010,
    mul_mulhu  = 3'b011,
    mul_div    = 3'b100,
    mul_divu   = 3'b101,
    mul_rem    = 3'b110,
    mul_remu   = 3'b111
  } mul_fn_t;

  function automatic logic fn_is_div(input mul_fn_t f);
    return (f == mul_div) || (f == mul_divu) || (f == mul_rem) || (f == mul_remu);
  endfunction

  function automatic logic fn_is_rem(input mul_fn_t f);
    return (f == mul_rem) || (f == mul_remu);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle, valid/ready in, valid/ack out.
// Optional feature macro: MUL_DIV_FAST_MUL_EN selects a single-cycle multiplier for multiplies.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  mul_fn_t          fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_o,
  input  logic             ack_i,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned      CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  mul_fn_t            fn_q;
  logic               neg_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   r_q;

  logic               is_div, is_rem, a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf, special, skip_busy;
  logic [WIDTH-1:0]   special_r;

  logic [WIDTH:0]     mul_sum, rem_shift;
  logic [WIDTH-1:0]   rem_diff, quo_signed, rem_signed, final_r;
  logic [2*WIDTH-1:0] mul_step, div_step, acc_step, prod_signed;

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign r       = r_q;

  always_comb begin
    is_div   = fn_is_div(fn);
    is_rem   = fn_is_rem(fn);
    a_signed = (fn == mul_mulh) || (fn == mul_mulhsu) || (fn == mul_div) || (fn == mul_rem);
    b_signed = (fn == mul_mulh) || (fn == mul_div) || (fn == mul_rem);
    a_neg    = a_signed & a[WIDTH-1];
    b_neg    = b_signed & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    // The remainder follows the dividend; products and quotients follow sign(a)^sign(b).
    res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);

    div_zero = is_div && (b == '0);
    div_ovf  = ((fn == mul_div) || (fn == mul_rem)) && (a == MOST_NEG) && (b == '1);
    special  = div_zero | div_ovf;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    special_r = '0;
    if (div_zero)     special_r = is_rem ? a : '1;
    else if (div_ovf) special_r = is_rem ? '0 : a;
  end

`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod, fast_signed;
  logic [WIDTH-1:0]   fast_r;
  assign fast_prod   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fast_signed = res_neg ? -fast_prod : fast_prod;
  assign fast_r      = (fn == mul_mul) ? fast_signed[WIDTH-1:0] : fast_signed[2*WIDTH-1:WIDTH];
  assign skip_busy   = special | ~is_div;
`else
  assign skip_busy   = special;
`endif

  // One iteration of either shift-add (multiply) or restoring shift-subtract (divide).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift[WIDTH-1:0] - operand_q;
    if (rem_shift >= {1'b0, operand_q}) div_step = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
    else                                div_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    acc_step    = fn_is_div(fn_q) ? div_step : mul_step;

    prod_signed = neg_q ? -acc_step : acc_step;
    quo_signed  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_signed  = neg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    if (fn_is_div(fn_q))      final_r = fn_is_rem(fn_q) ? rem_signed : quo_signed;
    else if (fn_q == mul_mul) final_r = prod_signed[WIDTH-1:0];
    else                      final_r = prod_signed[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = skip_busy ? DONE : BUSY;
      BUSY:    if (count_q == LAST_COUNT) state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fn_q      <= mul_mul;
      neg_q     <= 1'b0;
      count_q   <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      r_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          fn_q    <= fn;
          neg_q   <= res_neg;
          count_q <= '0;
          if (is_div) begin
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
            operand_q <= b_mag;
          end else begin
            acc_q     <= {{WIDTH{1'b0}}, b_mag};
            operand_q <= a_mag;
          end
          if (special) r_q <= special_r;
`ifdef MUL_DIV_FAST_MUL_EN
          else if (!is_div) r_q <= fast_r;
`endif
        end
        BUSY: begin
          acc_q   <= acc_step;
          count_q <= count_q + CW'(1);
          if (count_q == LAST_COUNT) r_q <= final_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=32; honours MUL_DIV_FAST_MUL_EN for multiply latency.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int unsigned WIDTH    = 32;
  localparam int          MAX_WAIT = 200;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int          MUL_LAT  = 1;
`else
  localparam int          MUL_LAT  = WIDTH + 1;
`endif
  localparam int          DIV_LAT  = WIDTH + 1;

  logic    clk = 1'b0;
  logic    reset, valid_i, ack_i, ready_o, valid_o;
  mul_fn_t fn;
  word_t   a, b, r;

  int      checks = 0;
  int      errors = 0;
  word_t   exp_q[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .fn      (fn),
    .a       (a),
    .b       (b),
    .valid_o (valid_o),
    .ack_i   (ack_i),
    .r       (r)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference behaviour of the RV32M operations using 64-bit arithmetic.
  function automatic word_t model(input mul_fn_t f, input word_t x, input word_t y);
    logic signed [63:0] sx, sy, suy;
    logic        [63:0] ux, uy, p;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    suy = uy;
    p   = '0;
    case (f)
      mul_mul:    begin p = ux * uy;  return p[31:0];  end
      mul_mulh:   begin p = sx * sy;  return p[63:32]; end
      mul_mulhsu: begin p = sx * suy; return p[63:32]; end
      mul_mulhu:  begin p = ux * uy;  return p[63:32]; end
      mul_div: begin
        if (y == 0) return '1;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      mul_rem: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return '0;
        p = sx % sy; return p[31:0];
      end
      mul_divu: return (y == 0) ? '1 : x / y;
      default:  return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic start_op(input mul_fn_t f, input word_t x, input word_t y);
    @(negedge clk);
    fn = f; a = x; b = y; valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    fn = mul_fn_t'(3'($urandom_range(7)));
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_result(output word_t got, output int lat, output bit saw_ready,
                             output bit timed_out);
    got = '0; lat = 0; saw_ready = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      lat++;
      if (valid_o) begin
        got = r; timed_out = 1'b0;
        break;
      end
      if (ready_o) saw_ready = 1'b1;
    end
  endtask

  task automatic ack_result();
    ack_i = 1'b1;
    @(posedge clk);
    #1;
    ack_i = 1'b0;
  endtask

  task automatic exec(input mul_fn_t f, input word_t x, input word_t y, input word_t expv,
                      output word_t got, output word_t expo, output int lat,
                      output bit saw_ready, output bit timed_out);
    exp_q.push_back(expv);
    start_op(f, x, y);
    wait_result(got, lat, saw_ready, timed_out);
    expo = exp_q.pop_front();
    if (!timed_out) ack_result();
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_i = 1'b0; ack_i = 1'b0; fn = mul_mul; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid_o); end
    checks++; if (r !== '0) begin errors++; $display("FAIL reset_r got %h expected 0", r); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_iterative();
    word_t got, expo; int lat; bit saw_ready, to;
    exec(mul_mul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, got, expo, lat, saw_ready, to);
    checks++; if (to) begin errors++; $display("FAIL mul_timeout no valid_o within %0d cycles", MAX_WAIT); end
    checks++; if (got !== expo) begin errors++; $display("FAIL mul_value got %h expected %h", got, expo); end
    checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mul_latency got %0d expected %0d", lat, MUL_LAT); end
    checks++; if (saw_ready) begin errors++; $display("FAIL mul_ready_busy got 1 expected 0 while busy"); end
  endtask

  task automatic test_high_mul();
    mul_fn_t fns [3] = '{mul_mulh, mul_mulhu, mul_mulhsu};
    word_t   xs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    word_t   ys  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    word_t   exps[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    word_t got, expo; int lat; bit saw_ready, to;
    for (int i = 0; i < 3; i++) begin
      exec(fns[i], xs[i], ys[i], exps[i], got, expo, lat, saw_ready, to);
      checks++; if (got !== expo) begin errors++; $display("FAIL high_mul_%0d got %h expected %h", i, got, expo); end
      checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL high_mul_lat_%0d got %0d expected %0d", i, lat, MUL_LAT); end
    end
  endtask

  task automatic test_divide();
    mul_fn_t fns [4] = '{mul_div, mul_rem, mul_divu, mul_remu};
    word_t   xs  [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
    word_t   ys  [4] = '{32'd3, 32'd3, 32'd3, 32'd3};
    word_t   exps[4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6, 32'd2};
    word_t got, expo; int lat; bit saw_ready, to;
    for (int i = 0; i < 4; i++) begin
      exec(fns[i], xs[i], ys[i], exps[i], got, expo, lat, saw_ready, to);
      checks++; if (got !== expo) begin errors++; $display("FAIL divide_%0d got %h expected %h", i, got, expo); end
      checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL divide_lat_%0d got %0d expected %0d", i, lat, DIV_LAT); end
    end
  endtask

  task automatic test_special();
    mul_fn_t fns [4] = '{mul_div, mul_remu, mul_div, mul_rem};
    word_t   xs  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    word_t   ys  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    word_t   exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    word_t got, expo; int lat; bit saw_ready, to;
    for (int i = 0; i < 4; i++) begin
      exec(fns[i], xs[i], ys[i], exps[i], got, expo, lat, saw_ready, to);
      checks++; if (got !== expo) begin errors++; $display("FAIL special_%0d got %h expected %h", i, got, expo); end
      checks++; if (lat != 1) begin errors++; $display("FAIL special_lat_%0d got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_early_ack();
    word_t expo;
    ack_i = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    start_op(mul_div, 32'd5, 32'd0);
    @(negedge clk);
    expo = exp_q.pop_front();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL early_ack_valid got %b expected 1", valid_o); end
    checks++; if (r !== expo) begin errors++; $display("FAIL early_ack_r got %h expected %h", r, expo); end
    @(negedge clk);
    checks++; if ({valid_o, ready_o} !== 2'b01) begin errors++; $display("FAIL early_ack_exit got valid=%b ready=%b expected 0/1", valid_o, ready_o); end
    ack_i = 1'b0;
  endtask

  task automatic test_back_pressure();
    word_t got, expo, held; int lat; bit saw_ready, to;
    exp_q.push_back(32'd14);
    start_op(mul_divu, 32'd100, 32'd7);
    wait_result(got, lat, saw_ready, to);
    expo = exp_q.pop_front();
    held = expo;
    checks++; if (got !== expo) begin errors++; $display("FAIL bp_value got %h expected %h", got, expo); end
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      fn = mul_fn_t'(3'(i));
      a  = $urandom;
      b  = $urandom;
      @(negedge clk);
      checks++; if (r !== held) begin errors++; $display("FAIL bp_hold_r_%0d got %h expected %h", i, r, held); end
      checks++; if ({valid_o, ready_o} !== 2'b10) begin errors++; $display("FAIL bp_hold_hs_%0d got valid=%b ready=%b expected 1/0", i, valid_o, ready_o); end
    end
    valid_i = 1'b0;
    ack_result();
    @(negedge clk);
    checks++; if ({valid_o, ready_o} !== 2'b01) begin errors++; $display("FAIL bp_release got valid=%b ready=%b expected 0/1", valid_o, ready_o); end
  endtask

  task automatic test_reset_mid_op();
    word_t got, expo; int lat; bit saw_ready, to;
    start_op(mul_divu, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({valid_o, ready_o} !== 2'b01) begin errors++; $display("FAIL midreset_hs got valid=%b ready=%b expected 0/1", valid_o, ready_o); end
    checks++; if (r !== '0) begin errors++; $display("FAIL midreset_r got %h expected 0", r); end
    @(negedge clk);
    reset = 1'b0;
    exec(mul_mul, 32'd3, 32'd4, 32'h0000_000C, got, expo, lat, saw_ready, to);
    checks++; if (got !== expo) begin errors++; $display("FAIL midreset_mul got %h expected %h", got, expo); end
    checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL midreset_lat got %0d expected %0d", lat, MUL_LAT); end
  endtask

  task automatic test_back_to_back();
    word_t got, expo, x, y; mul_fn_t f; int lat; bit saw_ready, to;
    for (int i = 0; i < 12; i++) begin
      f = mul_fn_t'(3'(i % 8));
      x = $urandom;
      y = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom));
      if (i == 10) begin f = mul_rem; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      exec(f, x, y, model(f, x, y), got, expo, lat, saw_ready, to);
      checks++; if (got !== expo) begin errors++; $display("FAIL b2b_%0d fn=%0d a=%h b=%h got %h expected %h", i, f, x, y, got, expo); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_iterative();
    test_high_mul();
    test_divide();
    test_special();
    test_early_ack();
    test_back_pressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
